lcd_update_ctrl: RTL and testbench

// - Wishbone master that sequences updates of the 4-digit LCD register slave (DIGIT0..3 at 0..3, EXTRAS at 4).
// - Takes a 16-bit hex/BCD value plus colon/decimal-point flags and encodes each nibble to 7-segment.
// - Writes only the registers whose value changed, waiting for ACK on each transfer.
// - Sits between control logic (counters, CPU-side glue) and the LCD slave on one Wishbone segment.

---
 rtl/lcd_update_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lcd_update_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_update_ctrl.sv
// lcd_update_ctrl: Wishbone write master that pushes a 4-digit 7-segment value plus
// colon/dot flags into the LCD register slave, writing only the registers that changed.
`default_nettype none

module lcd_update_ctrl #(
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          FORCE_ALL   = 1'b0,
  parameter int unsigned ACK_TMO     = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        upd_req_i,
  input  logic [15:0] upd_val_i,
  input  logic [3:0]  upd_ext_i,
  output logic        upd_busy_o,
  output logic        upd_done_o,
  output logic        upd_err_o,
  output logic [3:0]  wbm_adr_o,
  output logic [7:0]  wbm_dat_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i
);

  localparam logic [3:0] TMO_LAST = 4'(ACK_TMO - 1);
  localparam logic [2:0] IDX_END  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    WRITE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [3:0]  tmo;
  logic [15:0] val_q;
  logic [3:0]  ext_q;
  logic        pend;
  logic [15:0] pend_val;
  logic [3:0]  pend_ext;
  logic [7:0]  shadow [0:4];
  logic        shadow_valid;

  logic [3:0]  nib;
  logic [7:0]  cur_byte;
  logic [7:0]  shadow_cur;
  logic        skip;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // idx 0..3 selects a digit nibble, idx 4 selects the EXTRAS byte (never inverted)
  always_comb begin
    nib        = val_q[{idx[1:0], 2'b00} +: 4];
    cur_byte   = idx[2] ? {4'b0000, ext_q} : (seg7(nib) ^ {8{SEG_ACT_LOW}});
    shadow_cur = idx[2] ? shadow[4] : shadow[idx[1:0]];
    skip       = shadow_valid && !FORCE_ALL && (shadow_cur == cur_byte);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      idx          <= '0;
      tmo          <= '0;
      val_q        <= '0;
      ext_q        <= '0;
      pend         <= 1'b0;
      pend_val     <= '0;
      pend_ext     <= '0;
      shadow_valid <= 1'b0;
      for (int i = 0; i < 5; i++) shadow[i] <= '0;
      upd_busy_o   <= 1'b0;
      upd_done_o   <= 1'b0;
      upd_err_o    <= 1'b0;
      wbm_adr_o    <= '0;
      wbm_dat_o    <= '0;
      wbm_we_o     <= 1'b0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
    end else begin
      upd_done_o <= 1'b0;

      // Requests arriving mid-sequence collapse into a single pending slot
      if (upd_req_i && (state == CHECK || state == WRITE || state == GAP)) begin
        pend     <= 1'b1;
        pend_val <= upd_val_i;
        pend_ext <= upd_ext_i;
      end

      case (state)
        IDLE: begin
          if (upd_req_i) begin
            val_q      <= upd_val_i;
            ext_q      <= upd_ext_i;
            upd_err_o  <= 1'b0;
            upd_busy_o <= 1'b1;
            idx        <= '0;
            state      <= CHECK;
          end
        end

        CHECK: begin
          if (idx == IDX_END) begin
            upd_done_o <= 1'b1;
            state      <= DONE;
          end else if (skip) begin
            idx <= idx + 3'd1;
          end else begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= {1'b0, idx};
            wbm_dat_o <= cur_byte;
            tmo       <= '0;
            state     <= WRITE;
          end
        end

        WRITE: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            if (idx[2]) shadow[4] <= cur_byte;
            else        shadow[idx[1:0]] <= cur_byte;
            idx   <= idx + 3'd1;
            state <= GAP;
          end else if (tmo == TMO_LAST) begin
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_we_o     <= 1'b0;
            upd_err_o    <= 1'b1;
            shadow_valid <= 1'b0;
            upd_done_o   <= 1'b1;
            state        <= DONE;
          end else begin
            tmo <= tmo + 4'd1;
          end
        end

        // The slave edge-detects STB, so every transfer is separated by a low cycle
        GAP: state <= CHECK;

        DONE: begin
          if (!upd_err_o) shadow_valid <= 1'b1;
          if (upd_req_i || pend) begin
            val_q     <= upd_req_i ? upd_val_i : pend_val;
            ext_q     <= upd_req_i ? upd_ext_i : pend_ext;
            pend      <= 1'b0;
            upd_err_o <= 1'b0;
            idx       <= '0;
            state     <= CHECK;
          end else begin
            upd_busy_o <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_update_ctrl.sv
// tb_lcd_update_ctrl: drives two controllers (normal and inverted segments) against
// Wishbone slave models and a register-level reference model of the LCD shadow state.
`default_nettype none

module tb_lcd_update_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [15:0] val = '0;
  logic [3:0]  ext = '0;

  logic cyc0, stb0, we0, busy0, done0, err0, ack0;
  logic cyc1, stb1, we1, busy1, done1, err1, ack1;
  logic [3:0] adr0, adr1;
  logic [7:0] dat0, dat1;

  int total  = 0;
  int passed = 0;

  bit no_ack  = 1'b0;
  int ack_lat = 1;
  int cnt0 = 0, cnt1 = 0;
  int stbn0 = 0, stbn1 = 0;
  logic [3:0] stbadr0 = '0, stbadr1 = '0;

  logic [12:0] log0[$], log1[$], exp0[$], exp1[$];
  logic [7:0]  seg_tab [16];
  logic [7:0]  m_sh [2][5];
  bit          m_valid = 1'b0;
  bit          exp_err = 1'b0;
  int          exp_stb = 0;
  int          exp_adr = 0;
  logic [15:0] cur_v;
  logic [3:0]  cur_e;

  always #5 clk = ~clk;

  lcd_update_ctrl #(.SEG_ACT_LOW(1'b0), .FORCE_ALL(1'b0), .ACK_TMO(15)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .upd_req_i(req), .upd_val_i(val), .upd_ext_i(ext),
    .upd_busy_o(busy0), .upd_done_o(done0), .upd_err_o(err0),
    .wbm_adr_o(adr0), .wbm_dat_o(dat0), .wbm_we_o(we0), .wbm_cyc_o(cyc0),
    .wbm_stb_o(stb0), .wbm_ack_i(ack0));

  lcd_update_ctrl #(.SEG_ACT_LOW(1'b1), .FORCE_ALL(1'b0), .ACK_TMO(15)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .upd_req_i(req), .upd_val_i(val), .upd_ext_i(ext),
    .upd_busy_o(busy1), .upd_done_o(done1), .upd_err_o(err1),
    .wbm_adr_o(adr1), .wbm_dat_o(dat1), .wbm_we_o(we1), .wbm_cyc_o(cyc1),
    .wbm_stb_o(stb1), .wbm_ack_i(ack1));

  // Slave models: ack after ack_lat cycles of strobe, log each acknowledged write
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack0 <= 1'b0;
      cnt0 <= 0;
    end else begin
      if (cyc0 && stb0) begin
        stbn0   <= stbn0 + 1;
        stbadr0 <= adr0;
      end
      if (cyc0 && stb0 && ack0) begin
        log0.push_back({we0, adr0, dat0});
        ack0 <= 1'b0;
        cnt0 <= 0;
      end else if (cyc0 && stb0 && !no_ack) begin
        if (cnt0 >= ack_lat - 1) ack0 <= 1'b1;
        else cnt0 <= cnt0 + 1;
      end else begin
        ack0 <= 1'b0;
        cnt0 <= 0;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack1 <= 1'b0;
      cnt1 <= 0;
    end else begin
      if (cyc1 && stb1) begin
        stbn1   <= stbn1 + 1;
        stbadr1 <= adr1;
      end
      if (cyc1 && stb1 && ack1) begin
        log1.push_back({we1, adr1, dat1});
        ack1 <= 1'b0;
        cnt1 <= 0;
      end else if (cyc1 && stb1 && !no_ack) begin
        if (cnt1 >= ack_lat - 1) ack1 <= 1'b1;
        else cnt1 <= cnt1 + 1;
      end else begin
        ack1 <= 1'b0;
        cnt1 <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] m_byte(input int inst, input int k,
                                        input logic [15:0] v, input logic [3:0] e);
    logic [3:0] n;
    if (k == 4) return {4'h0, e};
    n = v[k*4 +: 4];
    return (inst == 1) ? ~seg_tab[n] : seg_tab[n];
  endfunction

  // Reference: a register is written when the shadow is untrusted or its byte differs
  task automatic m_expect(input logic [15:0] v, input logic [3:0] e, input bit na);
    bit aborted = 1'b0;
    logic [7:0] b0, b1;
    for (int k = 0; k < 5; k++) begin
      if (!aborted) begin
        b0 = m_byte(0, k, v, e);
        b1 = m_byte(1, k, v, e);
        if (!m_valid || m_sh[0][k] != b0) begin
          if (na) begin
            aborted = 1'b1;
            exp_stb = exp_stb + 15;
            exp_adr = k;
          end else begin
            exp0.push_back({1'b1, 4'(k), b0});
            exp1.push_back({1'b1, 4'(k), b1});
            m_sh[0][k] = b0;
            m_sh[1][k] = b1;
            exp_stb = exp_stb + ack_lat + 1;
          end
        end
      end
    end
    m_valid = !aborted;
    exp_err = aborted;
  endtask

  task automatic do_req(input logic [15:0] v, input logic [3:0] e);
    @(posedge clk); #1;
    req = 1'b1; val = v; ext = e;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 600) begin
      @(posedge clk); #1;
      n++;
      if (done0) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("done_inv_inst", done1, seen);
    lat = n + 1;
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_nwr0"}, log0.size(), exp0.size());
    for (int i = 0; i < exp0.size(); i++)
      if (i < log0.size()) chk({tag, "_wr0"}, log0[i], exp0[i]);
    chk({tag, "_nwr1"}, log1.size(), exp1.size());
    for (int i = 0; i < exp1.size(); i++)
      if (i < log1.size()) chk({tag, "_wr1"}, log1[i], exp1[i]);
    chk({tag, "_err0"}, err0, exp_err);
    chk({tag, "_err1"}, err1, exp_err);
    log0.delete(); log1.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic run_seq(input string tag, input logic [15:0] v, input logic [3:0] e);
    int lat, base0, base1, nexp;
    base0 = stbn0; base1 = stbn1; exp_stb = 0;
    do_req(v, e);
    m_expect(v, e, no_ack);
    nexp = exp0.size();
    wait_done(lat);
    chk({tag, "_busy_at_done"}, busy0, 1);
    chk({tag, "_stb_cycles0"}, stbn0 - base0, exp_stb);
    chk({tag, "_stb_cycles1"}, stbn1 - base1, exp_stb);
    if (nexp == 0 && !exp_err) chk({tag, "_nochange_latency"}, lat, 7);
    check_result(tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done0, 0);
    chk({tag, "_busy_clear"}, busy0, 0);
    cur_v = v; cur_e = e;
  endtask

  initial begin
    int lat, n, base0;
    logic [7:0] lit [5];
    logic [15:0] nv;
    logic [3:0]  ne;
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs0", {cyc0, stb0, we0, busy0, done0, err0, adr0, dat0}, 0);
    chk("reset_outs1", {cyc1, stb1, we1, busy1, done1, err1, adr1, dat1}, 0);
    rst = 1'b0;

    // First update, with literal segment values for the normal instance
    do_req(16'h1234, 4'hA);
    exp_stb = 0;
    m_expect(16'h1234, 4'hA, 1'b0);
    wait_done(lat);
    lit = '{8'h66, 8'h4F, 8'h5B, 8'h06, 8'h0A};
    for (int i = 0; i < 5; i++)
      chk("first_update_literal", (log0.size() > i) ? {5'd0, log0[i][7:0]} : 13'hx, {5'd0, lit[i]});
    check_result("first_update");
    @(posedge clk); #1;
    cur_v = 16'h1234; cur_e = 4'hA;

    run_seq("repeat_same", 16'h1234, 4'hA);
    run_seq("one_digit", 16'h1239, 4'hA);

    // Slave silent: one address times out, next identical request rewrites everything
    no_ack = 1'b1;
    run_seq("timeout", 16'h0000, 4'hA);
    chk("timeout_adr0", stbadr0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_held", err0, 1);
    no_ack = 1'b0;
    run_seq("after_timeout", 16'h0000, 4'hA);

    // Collapsing of requests made while busy
    exp_stb = 0;
    do_req(16'h1111, 4'hA);
    m_expect(16'h1111, 4'hA, 1'b0);
    repeat (2) @(posedge clk);
    do_req(16'h2222, 4'h5);
    do_req(16'h3333, 4'hA);
    m_expect(16'h3333, 4'hA, 1'b0);
    wait_done(lat);
    chk("pending_busy_held", busy0, 1);
    wait_done(lat);
    check_result("pending");
    @(posedge clk); #1;
    chk("pending_idle", busy0, 0);
    cur_v = 16'h3333; cur_e = 4'hA;

    // Inverted-segment instance, literal values
    exp_stb = 0;
    do_req(16'h0008, 4'h0);
    m_expect(16'h0008, 4'h0, 1'b0);
    wait_done(lat);
    lit = '{8'h80, 8'hC0, 8'hC0, 8'hC0, 8'h00};
    for (int i = 0; i < 5; i++)
      chk("act_low_literal", (log1.size() > i) ? {5'd0, log1[i][7:0]} : 13'hx, {5'd0, lit[i]});
    check_result("act_low");
    @(posedge clk); #1;

    // Reset in the middle of a write
    ack_lat = 2;
    do_req(16'hABCD, 4'h5);
    n = 0;
    while (!cyc0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_write", cyc0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_cyc0", cyc0, 0);
    chk("rst_stb0", stb0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_cyc1", cyc1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    log0.delete(); log1.delete();
    m_valid = 1'b0;
    base0 = stbn0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_resume", stbn0 - base0, 0);
    run_seq("after_reset", 16'hABCD, 4'h5);

    // Randomised updates with partial digit changes and varying ack latency
    for (int it = 0; it < 16; it++) begin
      ack_lat = $urandom_range(1, 3);
      nv = cur_v;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 1) == 1) nv[k*4 +: 4] = 4'($urandom_range(0, 15));
      ne = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : cur_e;
      run_seq("random", nv, ne);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
